// File: rtl/serv_dbus_pkg.sv
// ---------------------------------------------------------------------------
// serv_dbus_pkg
// Shared types and constants for the bit-serial data-bus buffer.
//   dbus_state_t : bus-cycle state (IDLE, WAIT, DONE)
//   DBUS_AW      : data-bus address width
//   lane_align() : shifts a read word down so the addressed byte sits at bit 0
// ---------------------------------------------------------------------------
package serv_dbus_pkg;

    localparam int DBUS_AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

    // Zero-filled right shift by whole bytes; lsb is the byte offset 0..3.
    function automatic logic [31:0] lane_align(input logic [31:0] rdt,
                                               input logic [1:0]  lsb);
        return rdt >> {lsb, 3'b000};
    endfunction

endpackage

// File: rtl/serv_dbus_timer.sv
// ---------------------------------------------------------------------------
// serv_dbus_timer
// Ack-wait counter for the data-bus buffer. Counts cycles spent waiting for
// an acknowledge and flags the cycle on which the wait reaches TIMEOUT.
//
// Ports
//   i_clk     in   clock
//   i_rst     in   synchronous active-high reset
//   i_clr     in   restart the count (entry into the wait state)
//   i_inc     in   one more cycle waited without acknowledge
//   o_expire  out  this waiting cycle brings the count to TIMEOUT
// ---------------------------------------------------------------------------
module serv_dbus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The increment that would land on TIMEOUT is the expiry; the buffer
    // leaves WAIT on that edge, so the counter never has to saturate.
    assign o_expire = i_inc && (cnt_q == LAST);

endmodule

// File: rtl/serv_dbus_buf.sv
// ---------------------------------------------------------------------------
// serv_dbus_buf
// Data-bus buffer between the bit-serial core and a Wishbone data bus.
// Store data is shifted in serially (already lane aligned by the shift
// count), a single parallel bus cycle is run, and load data is byte-aligned
// and shifted out one bit per counter step on o_q.
//
// Build option: define SERV_DBUS_TIMEOUT_EN to add an ack-wait timeout of
// TIMEOUT cycles (o_err pulses with o_ready). Without it the buffer waits
// for ack indefinitely and o_err is constant 0.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_cnt_en           serial bit-step enable
//   i_init             store-data shift phase
//   i_byte_valid       store shift permitted
//   i_rs2              serial store data, LSB first
//   i_req              one-cycle pulse starting a bus cycle
//   i_we, i_adr, i_sel direction, byte address, byte enables (with i_req)
//   o_dbus_adr/dat/sel/we/cyc   Wishbone master outputs (cyc doubles as stb)
//   i_dbus_rdt, i_dbus_ack      Wishbone read data and acknowledge
//   o_q                serial load bit (dat[0])
//   o_ready            one-cycle transaction-complete pulse
//   o_err              one-cycle timeout pulse
//
// State | meaning
// IDLE  | no bus cycle; store shift-in and load read-out allowed
// WAIT  | cyc asserted, data register frozen until ack (or timeout)
// DONE  | one-cycle ready pulse; load data already aligned in dat
// ---------------------------------------------------------------------------
module serv_dbus_buf
    import serv_dbus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cnt_en,
    input  logic               i_init,
    input  logic               i_byte_valid,
    input  logic               i_rs2,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [DBUS_AW-1:0] i_adr,
    input  logic [3:0]         i_sel,
    output logic [DBUS_AW-1:0] o_dbus_adr,
    output logic [31:0]        o_dbus_dat,
    output logic [3:0]         o_dbus_sel,
    output logic               o_dbus_we,
    output logic               o_dbus_cyc,
    input  logic [31:0]        i_dbus_rdt,
    input  logic               i_dbus_ack,
    output logic               o_q,
    output logic               o_ready,
    output logic               o_err
);

    dbus_state_t          state_q, state_d;
    logic [DBUS_AW-1:2]   adr_q, adr_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [1:0]           lsb_q, lsb_d;
    logic [31:0]          dat_q, dat_d;

    logic shift_in;
    logic shift_out;
    logic timeout_hit;

    assign shift_in  = i_init & i_cnt_en & i_byte_valid;
    assign shift_out = ~i_init & i_cnt_en;

`ifdef SERV_DBUS_TIMEOUT_EN
    logic err_q;

    serv_dbus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    ((state_q == IDLE) && i_req),
        .i_inc    ((state_q == WAIT) && !i_dbus_ack),
        .o_expire (timeout_hit)
    );

    // timeout_hit already excludes an ack in the same cycle, so ack wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign o_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        sel_d   = sel_q;
        lsb_d   = lsb_q;
        dat_d   = dat_q;
        unique case (state_q)
            IDLE: begin
                if (shift_in) begin
                    dat_d = {i_rs2, dat_q[31:1]};
                end else if (shift_out) begin
                    dat_d = {1'b0, dat_q[31:1]};
                end
                if (i_req) begin
                    adr_d   = i_adr[DBUS_AW-1:2];
                    we_d    = i_we;
                    sel_d   = i_sel;
                    lsb_d   = i_adr[1:0];
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_dbus_ack) begin
                    if (!we_q) begin
                        dat_d = lane_align(i_dbus_rdt, lsb_q);
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Store shift-in is still honoured here; read-out waits for
                // IDLE so the first load bit is not lost on the ready cycle.
                if (shift_in) begin
                    dat_d = {i_rs2, dat_q[31:1]};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            lsb_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            lsb_q   <= lsb_d;
            dat_q   <= dat_d;
        end
    end

    assign o_dbus_adr = {adr_q, 2'b00};
    assign o_dbus_dat = dat_q;
    assign o_dbus_sel = sel_q;
    assign o_dbus_we  = we_q;
    assign o_dbus_cyc = (state_q == WAIT);
    assign o_ready    = (state_q == DONE);
    assign o_q        = dat_q[0];

endmodule

// File: tb/tb_serv_dbus_buf.sv
module tb_serv_dbus_buf;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cnt_en, init, byte_valid, rs2;
    logic        req, we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dbus_adr, dbus_dat, dbus_rdt;
    logic [3:0]  dbus_sel;
    logic        dbus_we, dbus_cyc, dbus_ack;
    logic        q, ready, err;

    always #5 clk = ~clk;

    serv_dbus_buf #(.TIMEOUT(TMO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cnt_en     (cnt_en),
        .i_init       (init),
        .i_byte_valid (byte_valid),
        .i_rs2        (rs2),
        .i_req        (req),
        .i_we         (we),
        .i_adr        (adr),
        .i_sel        (sel),
        .o_dbus_adr   (dbus_adr),
        .o_dbus_dat   (dbus_dat),
        .o_dbus_sel   (dbus_sel),
        .o_dbus_we    (dbus_we),
        .o_dbus_cyc   (dbus_cyc),
        .i_dbus_rdt   (dbus_rdt),
        .i_dbus_ack   (dbus_ack),
        .o_q          (q),
        .o_ready      (ready),
        .o_err        (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: one outstanding transaction, described by
    // "busy on the bus", "completing this cycle" and a count of cycles waited.
    logic [31:0] m_dat;
    logic [31:0] m_adr;
    logic [3:0]  m_sel;
    logic        m_we;
    int          m_lsb;
    int          m_waited;
    bit          m_busy, m_ready, m_err, m_ok, m_was_done;

    always @(posedge clk) begin
        if (rst) begin
            m_dat = 0; m_adr = 0; m_sel = 0; m_we = 0; m_lsb = 0;
            m_waited = 0; m_busy = 0; m_ready = 0; m_err = 0; m_ok = 1;
        end else begin
            m_was_done = m_ready;
            m_ready = 0;
            m_err   = 0;
            if (m_busy) begin
                if (dbus_ack) begin
                    if (!m_we) m_dat = dbus_rdt >> (8 * m_lsb);
                    m_busy  = 0;
                    m_ready = 1;
                end else begin
`ifdef SERV_DBUS_TIMEOUT_EN
                    m_waited++;
                    if (m_waited == TMO) begin
                        m_busy  = 0;
                        m_ready = 1;
                        m_err   = 1;
                    end
`endif
                end
            end else begin
                if (init && cnt_en && byte_valid) m_dat = {rs2, m_dat[31:1]};
                else if (!init && cnt_en && !m_was_done) m_dat = m_dat >> 1;
                if (!m_was_done && req) begin
                    m_adr = adr; m_we = we; m_sel = sel; m_lsb = adr % 4;
                    m_busy = 1; m_waited = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc", dbus_cyc, m_busy);
            chk("ready", ready, m_ready);
            chk("err", err, m_err);
            chk("q", q, m_dat[0]);
            if (m_busy) begin
                chk("dbus_dat", dbus_dat, m_dat);
                chk("dbus_adr", dbus_adr, m_adr & 32'hFFFF_FFFC);
                chk("dbus_we", dbus_we, m_we);
                chk("dbus_sel", dbus_sel, m_sel);
            end
        end
    end

    task automatic idle_inputs();
        cnt_en = 0; init = 0; byte_valid = 0; rs2 = 0;
        req = 0; we = 0; adr = 0; sel = 0; dbus_rdt = 0; dbus_ack = 0;
    endtask

    task automatic shift_in(input logic [31:0] val, input int nvalid);
        for (int i = 0; i < 32; i++) begin
            init = 1; cnt_en = 1; byte_valid = (i < nvalid); rs2 = val[i];
            @(negedge clk);
        end
        init = 0; cnt_en = 0; byte_valid = 0; rs2 = 0;
    endtask

    task automatic do_req(input logic a_we, input logic [31:0] a_adr, input logic [3:0] a_sel);
        req = 1; we = a_we; adr = a_adr; sel = a_sel;
        @(negedge clk);
        req = 0;
    endtask

    task automatic do_ack(input logic [31:0] rdt);
        dbus_ack = 1; dbus_rdt = rdt;
        @(negedge clk);
        dbus_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_q;
        int ackdiv;
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_cyc", dbus_cyc, 0);
        chk("rst_ready", ready, 0);
        chk("rst_err", err, 0);
        chk("rst_q", q, 0);
        chk("rst_adr", dbus_adr, 0);
        chk("rst_sel", dbus_sel, 0);
        rst = 0;
        @(negedge clk);

        // aligned store
        shift_in(32'hDEADBEEF, 32);
        do_req(1, 32'h0000_1000, 4'hF);
        chk("st0_cyc", dbus_cyc, 1);
        chk("st0_dat", dbus_dat, 32'hDEADBEEF);
        @(negedge clk);
        do_ack(32'h0);
        chk("st0_ready", ready, 1);
        chk("st0_cyc_off", dbus_cyc, 0);
        @(negedge clk);
        chk("st0_ready_once", ready, 0);

        // offset store, byte offset 2
        shift_in(32'h0000ABCD, 16);
        do_req(1, 32'h0000_2002, 4'b1100);
        chk("st2_hi", {16'h0, dbus_dat[31:16]}, 32'h0000ABCD);
        chk("st2_adr", dbus_adr, 32'h0000_2000);
        do_ack(32'h0);
        chk("st2_ready", ready, 1);
        @(negedge clk);

        // offset load, byte offset 3
        do_req(0, 32'h0000_0103, 4'b1000);
        chk("ld3_adr", dbus_adr, 32'h0000_0100);
        chk("ld3_sel", dbus_sel, 4'b1000);
        do_ack(32'h80112233);
        chk("ld3_ready", ready, 1);
        @(negedge clk);
        exp_q = 32'h0000_0080;
        for (int i = 0; i < 32; i++) begin
            chk("ld3_q", q, exp_q[i]);
            cnt_en = 1;
            @(negedge clk);
        end
        cnt_en = 0;

        // ack delayed 5 cycles, data frozen while shift enables toggle
        shift_in(32'h12345678, 32);
        do_req(1, 32'h0000_0040, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            chk("dly_cyc", dbus_cyc, 1);
            chk("dly_dat", dbus_dat, 32'h12345678);
            cnt_en = 1; init = k[0]; byte_valid = 1; rs2 = 1;
            if (k == 5) begin dbus_ack = 1; dbus_rdt = 32'hFFFF_FFFF; end
            @(negedge clk);
        end
        idle_inputs();
        chk("dly_cyc_off", dbus_cyc, 0);
        chk("dly_ready", ready, 1);
        @(negedge clk);

        // reset in cycle 3 of a wait, with an ack on the same edge and after
        do_req(0, 32'h0000_0200, 4'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1; dbus_ack = 1; dbus_rdt = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("rstw_cyc", dbus_cyc, 0);
        chk("rstw_ready", ready, 0);
        rst = 0;
        @(negedge clk);
        chk("rstw_late_ack", ready, 0);
        dbus_ack = 0;
        @(negedge clk);
        chk("rstw_idle", ready, 0);

        // request during WAIT and ack in IDLE are ignored
        do_req(1, 32'h0000_0300, 4'h3);
        req = 1; we = 0; adr = 32'h0000_0400; sel = 4'hC;
        @(negedge clk);
        req = 0;
        chk("ign_adr", dbus_adr, 32'h0000_0300);
        chk("ign_we", dbus_we, 1);
        do_ack(32'h0);
        chk("ign_ready", ready, 1);
        @(negedge clk);
        chk("ign_no_second", dbus_cyc, 0);
        dbus_ack = 1;
        @(negedge clk);
        dbus_ack = 0;
        chk("ign_idle_ack", ready, 0);
        chk("ign_idle_cyc", dbus_cyc, 0);

`ifdef SERV_DBUS_TIMEOUT_EN
        do_req(0, 32'h0000_0500, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_wait", ready, 0);
            @(negedge clk);
        end
        chk("tmo_ready", ready, 1);
        chk("tmo_err", err, 1);
        @(negedge clk);
        chk("tmo_err_once", err, 0);
        do_req(0, 32'h0000_0600, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin dbus_ack = 1; dbus_rdt = 32'h0000_00FF; end
            @(negedge clk);
        end
        dbus_ack = 0;
        chk("tmo_ack_ready", ready, 1);
        chk("tmo_ack_err", err, 0);
        @(negedge clk);
`else
        do_req(0, 32'h0000_0700, 4'hF);
        for (int k = 1; k <= 20; k++) begin
            chk("long_wait_cyc", dbus_cyc, 1);
            @(negedge clk);
        end
        do_ack(32'h0000_0001);
        chk("long_ready", ready, 1);
        chk("long_err", err, 0);
        @(negedge clk);
`endif

        // randomized traffic against the reference model
        ackdiv = 3;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ackdiv = $urandom_range(1, 16);
            rst        = ($urandom_range(0, 299) == 0);
            req        = ($urandom_range(0, 4) == 0);
            we         = $urandom_range(0, 1);
            adr        = $urandom;
            sel        = $urandom_range(0, 15);
            dbus_ack   = ($urandom_range(1, ackdiv) == 1);
            dbus_rdt   = $urandom;
            cnt_en     = $urandom_range(0, 1);
            init       = $urandom_range(0, 1);
            byte_valid = $urandom_range(0, 1);
            rs2        = $urandom_range(0, 1);
            @(negedge clk);
        end
        rst = 0;
        idle_inputs();
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
